// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one synchronous FIFO among NUM_REQ producers.
// Throttles on full/almostfull and latches sticky wr_ack / overflow error flags.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          busy,
  output logic [1:0]                    state,
  output logic [CNT_WIDTH-1:0]          wr_count,
  output logic                          err_ack,
  output logic                          err_overflow
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_STALL  = 2'd2;

  if (NUM_REQ < 2 || NUM_REQ > 8 || FIFO_DEPTH < 2 || CNT_WIDTH < 1) begin : g_param_check
    $error("fifo_wr_arbiter: unsupported parameter set");
  end

  // First eligible index after last, wrapping; returns last when none is eligible.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] sel;
    logic             hit;
    int               idx;
    sel = last;
    hit = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(last) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!hit && elig[IDX_W'(idx)]) begin
        sel = IDX_W'(idx);
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  logic [NUM_REQ-1:0]    elig_p0;
  logic                  blocked_p0;
  logic                  vld_p0;
  logic [IDX_W-1:0]      pick_p0;
  logic [FIFO_WIDTH-1:0] data_p0;
  logic [1:0]            state_nxt;
  logic [IDX_W-1:0]      last_gnt;
  logic                  ack_pending;

  // ---- p0: eligibility, throttle and round-robin selection
  // A requester under gnt still shows the word just taken, so it sits out one cycle.
  assign elig_p0    = req & ~gnt;
  // The write issued this cycle occupies the last free slot when almostfull.
  assign blocked_p0 = fifo_full | (fifo_wr_en & fifo_almostfull);
  assign vld_p0     = (|elig_p0) & ~blocked_p0;
  assign pick_p0    = rr_pick(elig_p0, last_gnt);

  always_comb begin
    data_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_p0 == IDX_W'(i)) data_p0 = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  // Every state takes the same decision; STALL is left once unblocked or withdrawn.
  always_comb begin
    if (elig_p0 == '0)   state_nxt = ST_IDLE;
    else if (blocked_p0) state_nxt = ST_STALL;
    else                 state_nxt = ST_ACTIVE;
  end

  // ---- p1: registered grant and FIFO write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt          <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      last_gnt     <= IDX_W'(NUM_REQ - 1);
      wr_count     <= '0;
    end else if (vld_p0) begin
      gnt          <= NUM_REQ'(1) << pick_p0;
      fifo_wr_en   <= 1'b1;
      fifo_data_in <= data_p0;
      last_gnt     <= pick_p0;
      wr_count     <= wr_count + 1'b1;
    end else begin
      gnt          <= '0;
      fifo_wr_en   <= 1'b0;
    end
  end

  // ---- p1: FSM state and response checking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      ack_pending  <= 1'b0;
      err_ack      <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != ST_IDLE);
      ack_pending <= fifo_wr_en;
      if (ack_pending && !fifo_wr_ack) err_ack <= 1'b1;
      if (fifo_overflow) err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural FIFO plus a rule-level reference model
// of the arbiter, directed phases followed by randomized traffic.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              fifo_wr_en;
  logic [W-1:0]      fifo_data_in;
  logic              fifo_full;
  logic              fifo_almostfull;
  logic              fifo_wr_ack = 1'b0;
  logic              fifo_overflow = 1'b0;
  logic              busy;
  logic [1:0]        state;
  logic [CW-1:0]     wr_count;
  logic              err_ack;
  logic              err_overflow;

  bit           req_b [NREQ];
  logic [W-1:0] words [NREQ];
  int           fifo_cnt = 0;

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign req[g]              = req_b[g];
    assign req_data[g*W +: W]  = words[g];
  end
  assign fifo_full       = (fifo_cnt == DEPTH);
  assign fifo_almostfull = (fifo_cnt == DEPTH - 1);

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NREQ), .FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in), .fifo_full(fifo_full),
    .fifo_almostfull(fifo_almostfull), .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
    .busy(busy), .state(state), .wr_count(wr_count), .err_ack(err_ack), .err_overflow(err_overflow)
  );

  int errors = 0;
  int checks = 0;

  // reference model: granted index (-1 none), last winner, total accepted writes
  int           m_gidx, m_last, m_tot, m_state;
  bit           m_wr, m_ackp, m_eack, m_eovf;
  logic [W-1:0] m_data;

  // environment controls
  int hold_mask = 0;
  bit rand_en = 1'b0;
  int rd_mode = 0;
  bit rd_now = 1'b0;
  bit suppress_ack = 1'b0;
  bit force_ovf = 1'b0;
  int dut_wr = 0;
  int gq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gidx = -1; m_last = NREQ - 1; m_tot = 0; m_state = 0;
    m_wr = 1'b0; m_ackp = 1'b0; m_eack = 1'b0; m_eovf = 1'b0; m_data = '0;
  endtask

  task automatic step();
    bit           elig [NREQ];
    bit           any_elig, blk, found, n_wr, n_ackp, n_eack, n_eovf, e_ack, e_ovf, hb;
    int           n_gidx, n_last, n_tot, n_state, k, old_gidx, e_cnt;
    logic [W-1:0] n_data;
    any_elig = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_b[i] && (i != m_gidx);
      any_elig |= elig[i];
    end
    blk = (fifo_cnt == DEPTH) || (m_wr && fifo_cnt == DEPTH - 1);
    n_gidx = -1; n_wr = 1'b0; n_data = m_data; n_last = m_last; n_tot = m_tot; found = 1'b0;
    if (any_elig && !blk) begin
      for (int o = 1; o <= NREQ; o++) begin
        k = (m_last + o) % NREQ;
        if (!found && elig[k]) begin
          found = 1'b1; n_gidx = k; n_wr = 1'b1; n_data = words[k]; n_last = k; n_tot = m_tot + 1;
        end
      end
    end
    n_state = !any_elig ? 0 : (blk ? 2 : 1);
    n_ackp = m_wr;
    n_eack = m_eack | (m_ackp & !fifo_wr_ack);
    n_eovf = m_eovf | fifo_overflow;
    // behavioural FIFO reacting to what the DUT actually drives
    e_cnt = fifo_cnt; e_ack = 1'b0; e_ovf = force_ovf; force_ovf = 1'b0;
    if (fifo_wr_en === 1'b1) begin
      if (fifo_cnt < DEPTH) begin
        e_cnt++; e_ack = !suppress_ack; suppress_ack = 1'b0;
      end else e_ovf = 1'b1;
    end
    if (rd_now && fifo_cnt > 0) e_cnt--;

    @(posedge clk); #1;
    fifo_cnt = e_cnt; fifo_wr_ack = e_ack; fifo_overflow = e_ovf;
    old_gidx = m_gidx;
    if (!rst_n) model_reset();
    else begin
      m_gidx = n_gidx; m_wr = n_wr; m_data = n_data; m_last = n_last; m_tot = n_tot;
      m_state = n_state; m_ackp = n_ackp; m_eack = n_eack; m_eovf = n_eovf;
    end

    check("gnt", 32'(gnt), (m_gidx < 0) ? 0 : (1 << m_gidx));
    check("wr_en", 32'(fifo_wr_en), 32'(m_wr));
    check("data_in", 32'(fifo_data_in), 32'(m_data));
    check("state", 32'(state), m_state);
    check("busy", 32'(busy), (m_state != 0) ? 1 : 0);
    check("wr_count", 32'(wr_count), m_tot % 256);
    check("err_ack", 32'(err_ack), 32'(m_eack));
    check("err_overflow", 32'(err_overflow), 32'(m_eovf));
    check("wr_while_full", 32'(fifo_wr_en & fifo_full), 0);
    if (fifo_wr_en === 1'b1) begin
      dut_wr++;
      for (int i = 0; i < NREQ; i++) if (gnt == 4'(32'd1 << i)) gq.push_back(i);
    end

    // requesters refresh req/data at the edge that ends their gnt cycle
    for (int i = 0; i < NREQ; i++) begin
      hb = ((hold_mask >> i) & 1) != 0;
      if (i == old_gidx) words[i] = W'($urandom);
      if (rand_en) begin
        if (i == old_gidx) req_b[i] = ($urandom_range(0, 1) == 1);
        else if (!req_b[i]) begin
          if ($urandom_range(0, 1) == 1) begin req_b[i] = 1'b1; words[i] = W'($urandom); end
        end else if (i != m_gidx && $urandom_range(0, 15) == 0) req_b[i] = 1'b0;
      end else req_b[i] = hb;
    end
    case (rd_mode)
      1: rd_now = 1'b1;
      2: rd_now = ($urandom_range(0, 1) == 1);
      3: begin rd_now = 1'b1; rd_mode = 0; end
      default: rd_now = 1'b0;
    endcase
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_hold(input int mask);
    hold_mask = mask;
    for (int i = 0; i < NREQ; i++) req_b[i] = ((mask >> i) & 1) != 0;
  endtask

  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_data_in", 32'(fifo_data_in), 0);
    check("rst_state", 32'(state), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_count", 32'(wr_count), 0);
    check("rst_err_ack", 32'(err_ack), 0);
    check("rst_err_overflow", 32'(err_overflow), 0);
    steps(2);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin req_b[i] = 1'b0; words[i] = W'($urandom); end
    model_reset();
    steps(3);
    #2 rst_n = 1'b1;

    // reset mid-stream with all four requesting and the FIFO draining
    rd_mode = 1; set_hold(4'b1111);
    steps(6);
    reset_mid();

    // round-robin fairness straight after reset release
    gq.delete();
    steps(8);
    check("rr_len", gq.size(), 8);
    for (int j = 0; j < gq.size() && j < 8; j++) check("rr_seq", gq[j], j % 4);
    check("rr_wr_count", 32'(wr_count), 8);

    // single requester: one write every other cycle
    set_hold(0); steps(4);
    set_hold(4'b0100); gq.delete(); dut_wr = 0;
    steps(20);
    check("single_duty", dut_wr, 10);
    for (int j = 0; j < gq.size(); j++) check("single_idx", gq[j], 2);

    // full throttle with no reads
    set_hold(0); rd_mode = 1; steps(10);
    rd_mode = 0; rd_now = 1'b0; set_hold(4'b0011); dut_wr = 0;
    steps(40);
    check("full_writes", dut_wr, 8);
    check("full_state", 32'(state), 2);
    check("full_no_ovf", 32'(err_overflow), 0);
    check("full_level", fifo_cnt, DEPTH);
    rd_mode = 3; dut_wr = 0;
    steps(20);
    check("one_read_one_write", dut_wr, 1);
    check("refull_level", fifo_cnt, DEPTH);

    // missing write acknowledge
    rd_mode = 1; suppress_ack = 1'b1;
    steps(10);
    check("ack_err_set", 32'(err_ack), 1);
    set_hold(0); steps(10);
    check("ack_err_sticky", 32'(err_ack), 1);
    check("ack_no_ovf", 32'(err_overflow), 0);

    // overflow pulse
    force_ovf = 1'b1;
    step();
    check("ovf_pulse_seen", 32'(err_overflow), 0);
    step();
    check("ovf_err_set", 32'(err_overflow), 1);
    steps(5);
    check("ovf_err_sticky", 32'(err_overflow), 1);
    reset_mid();

    // randomized traffic with random reads and withdrawals
    rand_en = 1'b1; rd_mode = 2;
    steps(300);

    // accepted-write counter wrap
    rand_en = 1'b0; rd_mode = 1; set_hold(4'b1111);
    reset_mid();
    for (int n = 0; n < 400 && m_tot < 256; n++) step();
    check("wrap_reached", m_tot, 256);
    check("wrap_zero", 32'(wr_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
